api_pll_sched: RTL

PLL configuration scheduler feeding the PLL-config FIFO (pllf) that the API channel controller drains while it streams work words to the chips. One register-level command (three PLL words plus a miner/chip target, each optionally "all") is expanded into one 104-bit pllf entry per addressed chip. Entries are pushed under FIFO back-pressure, and then the block waits for the channel controller to consume them. Status is reported back to the register file.

---
 rtl/api_pll_sched_pkg.sv | 26 ++
 rtl/api_pll_iter.sv | 60 ++++++
 rtl/api_pll_sched.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/api_pll_sched_pkg.sv
// Shared definitions for the PLL-config scheduler and the channel-controller decode of
// pllf entries.
package api_pll_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPush  = 2'd1,
    StDrain = 2'd2
  } pll_state_e;

  localparam int unsigned PLLF_W    = 104;
  localparam int unsigned MINER_LSB = 0;
  localparam int unsigned CHIP_LSB  = 4;
  localparam int unsigned W0_LSB    = 8;
  localparam int unsigned W1_LSB    = 40;
  localparam int unsigned W2_LSB    = 72;

  localparam logic [3:0] ALL_ID = 4'hF;

  function automatic logic [PLLF_W-1:0] pack_entry(input logic [31:0] w2, input logic [31:0] w1,
                                                   input logic [31:0] w0, input logic [3:0] chip,
                                                   input logic [3:0] miner);
    return {w2, w1, w0, chip, miner};
  endfunction

endpackage

// File: rtl/api_pll_iter.sv
// Nested miner/chip counter: chip is the inner loop, miner the outer one. Holds at the final
// position; a fixed target never advances.
module api_pll_iter #(
  parameter int unsigned MAX_CHIP = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       adv,
  input  logic       all_miner,
  input  logic       all_chip,
  input  logic [3:0] miner_init,
  input  logic [3:0] chip_init,
  input  logic [3:0] miner_max,
  output logic [3:0] miner,
  output logic [3:0] chip,
  output logic       last
);

  localparam logic [3:0] ChipLast = 4'(MAX_CHIP - 1);

  logic [3:0] miner_q, miner_d;
  logic [3:0] chip_q, chip_d;
  logic       chip_end, miner_end;

  assign chip_end  = !all_chip || (chip_q == ChipLast);
  assign miner_end = !all_miner || (miner_q == miner_max);
  assign last      = chip_end && miner_end;

  always_comb begin
    miner_d = miner_q;
    chip_d  = chip_q;
    if (load) begin
      miner_d = miner_init;
      chip_d  = chip_init;
    end else if (adv && !last) begin
      if (!chip_end) begin
        chip_d = chip_q + 4'd1;
      end else begin
        // chip wrapped, so only an "all miners" sweep can still have work left
        chip_d  = all_chip ? 4'd0 : chip_q;
        miner_d = miner_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miner_q <= 4'd0;
      chip_q  <= 4'd0;
    end else begin
      miner_q <= miner_d;
      chip_q  <= chip_d;
    end
  end

  assign miner = miner_q;
  assign chip  = chip_q;

endmodule

// File: rtl/api_pll_sched.sv
// Expands one register-level PLL command into pllf entries, pushes them under back-pressure,
// then waits for the channel controller to drain the FIFO.
module api_pll_sched
  import api_pll_sched_pkg::*;
#(
  parameter int unsigned API_NUM  = 10,
  parameter int unsigned MAX_CHIP = 5,
  parameter int unsigned DRAIN_TO = 1 << 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_rst,
  input  logic              reg_pll_start,
  input  logic              reg_pll_abort,
  input  logic [3:0]        reg_pll_miner,
  input  logic [3:0]        reg_pll_chip,
  input  logic [31:0]       reg_pll_word0,
  input  logic [31:0]       reg_pll_word1,
  input  logic [31:0]       reg_pll_word2,
  input  logic [5:0]        reg_ch_num,
  output logic              reg_pll_busy,
  output logic              reg_pll_done,
  output logic              reg_pll_err,
  input  logic              pllf_full,
  input  logic              pllf_empty,
  output logic              pllf_wr_en,
  output logic [PLLF_W-1:0] pllf_din
);

  localparam logic [24:0] DrainLast = 25'(DRAIN_TO - 1);
  localparam logic [5:0]  ApiNum    = 6'(API_NUM);
  localparam logic [3:0]  MaxChip   = 4'(MAX_CHIP);

  pll_state_e state_q, state_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [24:0] drain_q, drain_d;
  logic [31:0] w0_q, w1_q, w2_q;
  logic        all_miner_q, all_chip_q;
  logic [3:0]  miner_max_q;
  logic        srst, load, illegal, last;
  logic [3:0]  miner, chip;
  logic [5:0]  ch_eff;

  assign srst = rst | reg_rst;

  assign illegal = ((reg_pll_miner != ALL_ID) && ({2'b00, reg_pll_miner} >= reg_ch_num)) ||
                   ((reg_pll_chip != ALL_ID) && (reg_pll_chip >= MaxChip)) ||
                   ((reg_pll_miner == ALL_ID) && (reg_ch_num == 6'd0));

  // Miner ids above API_NUM-1 do not exist, so a larger ch_num is clamped for the sweep.
  assign ch_eff = (reg_ch_num > ApiNum) ? ApiNum : reg_ch_num;

  assign pllf_wr_en   = (state_q == StPush) && !pllf_full && !reg_pll_abort;
  assign reg_pll_busy = (state_q != StIdle);
  assign reg_pll_done = done_q;
  assign reg_pll_err  = err_q;
  assign pllf_din     = pack_entry(w2_q, w1_q, w0_q, chip, miner);

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    err_d   = err_q;
    drain_d = drain_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (reg_pll_start && !reg_pll_abort) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            load    = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            state_d = StPush;
          end
        end
      end
      StPush: begin
        if (reg_pll_abort) begin
          state_d = StIdle;
        end else if (pllf_wr_en && last) begin
          state_d = StDrain;
          drain_d = 25'd0;
        end
      end
      StDrain: begin
        if (reg_pll_abort) begin
          state_d = StIdle;
        end else if (pllf_empty) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (drain_q == DrainLast) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          drain_d = drain_q + 25'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= StIdle;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      drain_q     <= 25'd0;
      w0_q        <= 32'd0;
      w1_q        <= 32'd0;
      w2_q        <= 32'd0;
      all_miner_q <= 1'b0;
      all_chip_q  <= 1'b0;
      miner_max_q <= 4'd0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      drain_q <= drain_d;
      if (load) begin
        w0_q        <= reg_pll_word0;
        w1_q        <= reg_pll_word1;
        w2_q        <= reg_pll_word2;
        all_miner_q <= (reg_pll_miner == ALL_ID);
        all_chip_q  <= (reg_pll_chip == ALL_ID);
        miner_max_q <= 4'(ch_eff - 6'd1);
      end
    end
  end

  api_pll_iter #(
    .MAX_CHIP(MAX_CHIP)
  ) u_iter (
    .clk       (clk),
    .rst       (srst),
    .load      (load),
    .adv       (pllf_wr_en),
    .all_miner (load ? (reg_pll_miner == ALL_ID) : all_miner_q),
    .all_chip  (load ? (reg_pll_chip == ALL_ID) : all_chip_q),
    .miner_init((reg_pll_miner == ALL_ID) ? 4'd0 : reg_pll_miner),
    .chip_init ((reg_pll_chip == ALL_ID) ? 4'd0 : reg_pll_chip),
    .miner_max (miner_max_q),
    .miner     (miner),
    .chip      (chip),
    .last      (last)
  );

endmodule
